// File: rtl/vc_state_tracker.sv
// Per-output-port, per-VC state and credit tracker driving vc_busy for the VC allocator.
// Optional drain watchdog enabled by defining VC_TIMEOUT_EN.
module vc_state_tracker #(
  parameter int unsigned PORT_NUM    = 5,
  parameter int unsigned VC_NUM      = 4,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [PORT_NUM-1:0]                     alloc_vld,
  input  logic [PORT_NUM-1:0][2:0]                alloc_port,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]         alloc_vc,
  input  logic [PORT_NUM-1:0]                     flit_vld,
  input  logic [PORT_NUM-1:0][$clog2(VC_NUM)-1:0] flit_vc,
  input  logic [PORT_NUM-1:0]                     flit_tail,
  input  logic [PORT_NUM-1:0]                     credit_vld,
  input  logic [PORT_NUM-1:0][$clog2(VC_NUM)-1:0] credit_vc,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]         vc_busy,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]         vc_credit_ok,
  output logic [PORT_NUM-1:0]                     err_alloc,
  output logic [PORT_NUM-1:0]                     err_credit
);

  localparam int unsigned CrW = $clog2(BUF_DEPTH + 1);
  localparam logic [CrW-1:0] CrMax = CrW'(BUF_DEPTH);
  localparam logic [CrW-1:0] CrOne = CrW'(1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} vc_state_e;

  vc_state_e             state_q  [PORT_NUM][VC_NUM];
  vc_state_e             state_d  [PORT_NUM][VC_NUM];
  logic [CrW-1:0]        credit_q [PORT_NUM][VC_NUM];
  logic [CrW-1:0]        credit_d [PORT_NUM][VC_NUM];
  logic [PORT_NUM-1:0]   err_alloc_q, err_alloc_d;
  logic [PORT_NUM-1:0]   err_credit_q, err_credit_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0] hit, multi;

`ifdef VC_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);
  logic [TmoW-1:0] tmo_q [PORT_NUM][VC_NUM];
  logic [TmoW-1:0] tmo_d [PORT_NUM][VC_NUM];
`endif

  // Out-of-range ports and non-one-hot VC masks never match, so they drop silently.
  always_comb begin
    hit   = '0;
    multi = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int i = 0; i < PORT_NUM; i++) begin
          if (alloc_vld[i] && $onehot(alloc_vc[i]) && alloc_vc[i][v] &&
              (int'(alloc_port[i]) == o)) begin
            multi[o][v] = multi[o][v] | hit[o][v];
            hit[o][v]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    logic send, ret, send_ok;
    send         = 1'b0;
    ret          = 1'b0;
    send_ok      = 1'b0;
    err_alloc_d  = err_alloc_q;
    err_credit_d = err_credit_q;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        send    = flit_vld[o] && (int'(flit_vc[o]) == v);
        ret     = credit_vld[o] && (int'(credit_vc[o]) == v);
        send_ok = send && (state_q[o][v] == StActive) && (credit_q[o][v] != '0);
        state_d[o][v]  = state_q[o][v];
        credit_d[o][v] = credit_q[o][v];

        if (send && !send_ok) err_credit_d[o] = 1'b1;
        // A valid send paired with a return nets to zero and cannot overflow.
        if (send_ok && !ret) begin
          credit_d[o][v] = credit_q[o][v] - CrOne;
        end else if (ret && !send_ok) begin
          if (credit_q[o][v] == CrMax) err_credit_d[o] = 1'b1;
          else                         credit_d[o][v] = credit_q[o][v] + CrOne;
        end

        case (state_q[o][v])
          StIdle: begin
            if (hit[o][v]) begin
              state_d[o][v] = StActive;
              if (multi[o][v]) err_alloc_d[o] = 1'b1;
            end
          end
          StActive: begin
            if (hit[o][v]) err_alloc_d[o] = 1'b1;
            if (send_ok && flit_tail[o]) begin
              state_d[o][v] = (credit_d[o][v] == CrMax) ? StIdle : StDrain;
            end
          end
          StDrain: begin
            if (hit[o][v]) err_alloc_d[o] = 1'b1;
            if (credit_d[o][v] == CrMax) state_d[o][v] = StIdle;
          end
          default: state_d[o][v] = StIdle;
        endcase

`ifdef VC_TIMEOUT_EN
        tmo_d[o][v] = tmo_q[o][v];
        if (state_q[o][v] != StDrain) begin
          tmo_d[o][v] = '0;
        end else if (state_d[o][v] == StDrain) begin
          if (tmo_q[o][v] == TmoLast) begin
            state_d[o][v]   = StIdle;
            credit_d[o][v]  = CrMax;
            err_credit_d[o] = 1'b1;
          end else begin
            tmo_d[o][v] = tmo_q[o][v] + TmoOne;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          state_q[o][v]  <= StIdle;
          credit_q[o][v] <= CrMax;
`ifdef VC_TIMEOUT_EN
          tmo_q[o][v]    <= '0;
`endif
        end
      end
      err_alloc_q  <= '0;
      err_credit_q <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
`ifdef VC_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
      err_alloc_q  <= err_alloc_d;
      err_credit_q <= err_credit_d;
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        vc_busy[o][v]      = (state_q[o][v] != StIdle);
        vc_credit_ok[o][v] = (credit_q[o][v] != '0);
      end
    end
  end

  assign err_alloc  = err_alloc_q;
  assign err_credit = err_credit_q;

endmodule

// File: tb/tb_vc_state_tracker.sv
// Directed, table-driven bench for vc_state_tracker; define VC_TIMEOUT_EN to cover the watchdog.
module tb_vc_state_tracker;

  localparam int P = 5;
  localparam int V = 4;
`ifdef VC_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [P-1:0]        alloc_vld;
  logic [P-1:0][2:0]   alloc_port;
  logic [P-1:0][V-1:0] alloc_vc;
  logic [P-1:0]        flit_vld;
  logic [P-1:0][1:0]   flit_vc;
  logic [P-1:0]        flit_tail;
  logic [P-1:0]        credit_vld;
  logic [P-1:0][1:0]   credit_vc;
  logic [P-1:0][V-1:0] vc_busy;
  logic [P-1:0][V-1:0] vc_credit_ok;
  logic [P-1:0]        err_alloc;
  logic [P-1:0]        err_credit;

  always #5 clk = ~clk;

  vc_state_tracker #(
    .PORT_NUM   (P),
    .VC_NUM     (V),
    .BUF_DEPTH  (4),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_vld   (alloc_vld),
    .alloc_port  (alloc_port),
    .alloc_vc    (alloc_vc),
    .flit_vld    (flit_vld),
    .flit_vc     (flit_vc),
    .flit_tail   (flit_tail),
    .credit_vld  (credit_vld),
    .credit_vc   (credit_vc),
    .vc_busy     (vc_busy),
    .vc_credit_ok(vc_credit_ok),
    .err_alloc   (err_alloc),
    .err_credit  (err_credit)
  );

  typedef struct packed {
    logic [P-1:0]        a_vld;
    logic [P-1:0][2:0]   a_port;
    logic [P-1:0][V-1:0] a_vc;
    logic [P-1:0]        f_vld;
    logic [P-1:0][1:0]   f_vc;
    logic [P-1:0]        f_tail;
    logic [P-1:0]        c_vld;
    logic [P-1:0][1:0]   c_vc;
    logic [P-1:0][V-1:0] e_busy;
    logic [P-1:0][V-1:0] e_ok;
    logic [P-1:0]        e_ea;
    logic [P-1:0]        e_ec;
  } vec_t;

  vec_t                tbl[$];
  vec_t                v;
  logic [P-1:0][V-1:0] eb, eok;
  logic [P-1:0]        ea, ec;
  int                  n_chk = 0;
  int                  n_fail = 0;

  task automatic nv();
    v = '0;
  endtask

  task automatic alloc(input int i, input int o, input int vc);
    v.a_vld[i]  = 1'b1;
    v.a_port[i] = 3'(o);
    v.a_vc[i]   = 4'(1 << vc);
  endtask

  task automatic flit(input int o, input int vc, input bit tail);
    v.f_vld[o]  = 1'b1;
    v.f_vc[o]   = 2'(vc);
    v.f_tail[o] = tail;
  endtask

  task automatic cred(input int o, input int vc);
    v.c_vld[o] = 1'b1;
    v.c_vc[o]  = 2'(vc);
  endtask

  task automatic push();
    v.e_busy = eb;
    v.e_ok   = eok;
    v.e_ea   = ea;
    v.e_ec   = ec;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t x);
    alloc_vld  = x.a_vld;
    alloc_port = x.a_port;
    alloc_vc   = x.a_vc;
    flit_vld   = x.f_vld;
    flit_vc    = x.f_vc;
    flit_tail  = x.f_tail;
    credit_vld = x.c_vld;
    credit_vc  = x.c_vc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vc_busy"},      32'(vc_busy),      32'(eb));
    check({tag, ".vc_credit_ok"}, 32'(vc_credit_ok), 32'(eok));
    check({tag, ".err_alloc"},    32'(err_alloc),    32'(ea));
    check({tag, ".err_credit"},   32'(err_credit),   32'(ec));
  endtask

  initial begin
    vec_t zero;
    zero = '0;
    apply(zero);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    eb = '0; eok = '1; ea = '0; ec = '0;
    check_all("reset_idle");

    // Packet on p2/VC0: 3 flits (tail last), then 3 credits back to idle.
    nv(); alloc(1, 2, 0);            eb[2][0] = 1'b1; push();
    nv(); flit(2, 0, 0);                              push();
    nv(); flit(2, 0, 0);                              push();
    nv(); flit(2, 0, 1);                              push();
    nv(); cred(2, 0);                                 push();
    nv(); cred(2, 0);                                 push();
    nv(); cred(2, 0);                eb[2][0] = 1'b0; push();
    // Conflicting grants to p4/VC2.
    nv(); alloc(0, 4, 2); alloc(3, 4, 2); eb[4][2] = 1'b1; ea[4] = 1'b1; push();
    // Exhaust credits on p1/VC1, then send one more.
    nv(); alloc(2, 1, 1);            eb[1][1] = 1'b1; push();
    nv(); flit(1, 1, 0);                              push();
    nv(); flit(1, 1, 0);                              push();
    nv(); flit(1, 1, 0);                              push();
    nv(); flit(1, 1, 0);             eok[1][1] = 1'b0; push();
    nv(); flit(1, 1, 0);             ec[1] = 1'b1;    push();
    nv(); cred(1, 1);                eok[1][1] = 1'b1; push();
    // Out-of-range port and non-one-hot VC mask are dropped.
    nv(); alloc(0, 5, 0); v.a_vld[2] = 1'b1; v.a_port[2] = 3'd3; v.a_vc[2] = 4'b0011; push();
    // p0/VC3: send+return cancels, then overflow.
    nv(); alloc(4, 0, 3);            eb[0][3] = 1'b1; push();
    nv(); flit(0, 3, 0);                              push();
    nv(); flit(0, 3, 0);                              push();
    nv(); flit(0, 3, 0); cred(0, 3);                  push();
    nv(); cred(0, 3);                                 push();
    nv(); cred(0, 3);                                 push();
    nv(); cred(0, 3);                ec[0] = 1'b1;    push();
    nv(); alloc(1, 0, 3);            ea[0] = 1'b1;    push();
    nv(); flit(3, 0, 0);             ec[3] = 1'b1;    push();
    // Single-flit packet with return on the tail cycle goes straight to idle.
    nv(); alloc(0, 2, 1);            eb[2][1] = 1'b1; push();
    nv(); flit(2, 1, 1); cred(2, 1); eb[2][1] = 1'b0; push();
    // Alloc on the drain->idle edge is rejected.
    nv(); alloc(0, 2, 2);            eb[2][2] = 1'b1; push();
    nv(); flit(2, 2, 1);                              push();
    nv(); cred(2, 2); alloc(1, 2, 2); eb[2][2] = 1'b0; ea[2] = 1'b1; push();
    nv();                                             push();

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k]);
      step();
      eb = tbl[k].e_busy; eok = tbl[k].e_ok; ea = tbl[k].e_ea; ec = tbl[k].e_ec;
      check_all($sformatf("vec%0d", k));
    end
    apply(zero);

    // Drain with no credit return on p4/VC0.
    nv(); alloc(0, 4, 0); apply(v); step(); eb[4][0] = 1'b1;
    check_all("drain_alloc");
    nv(); flit(4, 0, 1); apply(v); step(); apply(zero);
    check_all("drain_tail");
`ifdef VC_TIMEOUT_EN
    repeat (TMO - 1) step();
    check_all("tmo_before");
    step();
    eb[4][0] = 1'b0; ec[4] = 1'b1;
    check_all("tmo_fired");
`else
    repeat (100) step();
    check_all("drain_hold");
`endif

    // Reset in the middle of activity clears everything.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    eb = '0; eok = '1; ea = '0; ec = '0;
    check_all("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_state_tracker.md
Name: vc_state_tracker

Overview:
- Per-output-port, per-VC status keeper that produces the `vc_busy` vector consumed by the VC allocator.
- Records VC allocations from the allocator's grants and tracks downstream buffer credits per VC.
- Releases a VC only after its tail flit has departed and all downstream credits have returned.
- Sits between the allocator grant outputs, the switch traversal stage and the link credit-return path.

Parameters:
- PORT_NUM, 5, number of router ports (input and output).
- VC_NUM, 4, VCs per output port.
- BUF_DEPTH, 4, downstream buffer depth per VC; initial and maximum credit count.
- TIMEOUT_CYC, 255, drain watchdog limit. Used only with VC_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- alloc_vld  in  [PORT_NUM-1:0]  input port i received a VC grant this cycle.
- alloc_port  in  [2:0] x PORT_NUM  target output port of input i.
- alloc_vc  in  [VC_NUM-1:0] x PORT_NUM  one-hot granted VC of input i.
- flit_vld  in  [PORT_NUM-1:0]  flit departs on output port o this cycle.
- flit_vc  in  [$clog2(VC_NUM)-1:0] x PORT_NUM  VC index of the departing flit.
- flit_tail  in  [PORT_NUM-1:0]  departing flit is a tail.
- credit_vld  in  [PORT_NUM-1:0]  one credit returned on output port o.
- credit_vc  in  [$clog2(VC_NUM)-1:0] x PORT_NUM  VC index of the returned credit.
- vc_busy  out  [VC_NUM-1:0] x PORT_NUM  VC not IDLE; feeds the allocator.
- vc_credit_ok  out  [VC_NUM-1:0] x PORT_NUM  credit count > 0.
- err_alloc  out  [PORT_NUM-1:0]  sticky, per output port; alloc conflict or alloc to a non-IDLE VC.
- err_credit  out  [PORT_NUM-1:0]  sticky, per output port; send with zero credits, flit on an IDLE VC, or credit overflow.

Behaviour:
- Reset, rst_n=0 at posedge clk:
  - every (o,v) goes to IDLE with credit = BUF_DEPTH;
  - vc_busy = 0, vc_credit_ok = all 1, err_alloc = 0, err_credit = 0.
  - Reset mid-operation discards all state, including in-flight ACTIVE/DRAIN VCs.
- State per (o,v): IDLE, ACTIVE, DRAIN. vc_busy[o][v] = (state != IDLE). All outputs are registered.
- IDLE -> ACTIVE:
  - An alloc_vld[i] with alloc_port[i]=o and alloc_vc[i][v]=1 moves (o,v) to ACTIVE at the same edge.
  - vc_busy rises the cycle after the grant is sampled.
- Alloc conflict: two or more inputs target the same (o,v) in one cycle.
  - (o,v) still goes to ACTIVE; the lowest input index is the nominal owner.
  - err_alloc[o] is set.
- Alloc to an ACTIVE or DRAIN VC: ignored for state; err_alloc[o] set.
- alloc_port >= PORT_NUM or non-one-hot alloc_vc: request ignored, no error flag.
- Flit departure, flit_vld[o] on VC v:
  - ACTIVE with credit > 0: credit decrements.
  - Tail flit: ACTIVE -> DRAIN at the same edge.
  - Credit = 0, or VC in IDLE or DRAIN: credit and state unchanged; err_credit[o] set.
- Credit return, credit_vld[o] on VC v:
  - credit increments in any state;
  - at BUF_DEPTH the count saturates and err_credit[o] is set.
- Simultaneous valid send and credit return on the same (o,v): net credit change 0, no error.
- DRAIN -> IDLE at the edge where next-credit == BUF_DEPTH, including a return arriving on the tail cycle.
  - Alloc in that same cycle is treated as a non-IDLE alloc: ignored, error set.
- Single-flit packet (head = tail) on an ACTIVE VC: ACTIVE -> DRAIN directly.
- Credit counter width: $clog2(BUF_DEPTH+1). vc_credit_ok = (credit != 0) of the registered count.

Optional Feature:
- Macro: VC_TIMEOUT_EN.
- Defined:
  - per-(o,v) counter of width $clog2(TIMEOUT_CYC+1), cleared on DRAIN entry;
  - counts each cycle spent in DRAIN;
  - on reaching TIMEOUT_CYC the VC is forced to IDLE, credit restored to BUF_DEPTH, err_credit[o] set.
- Undefined: no counter logic; a DRAIN VC waits for credits indefinitely.

Test Plan:
- Reset then idle 10 cycles -> vc_busy all 0, vc_credit_ok all 1, errors 0.
- Input 1 granted port 2 VC0, then 3 flits with tail on the 3rd, no credits -> vc_busy[2][0]=1 from cycle+1; credit 4->1; state DRAIN; 3 credits returned -> IDLE, vc_busy[2][0]=0 the cycle after the last credit.
- Inputs 0 and 3 both granted port 4 VC2 in the same cycle -> vc_busy[4][2]=1, err_alloc[4]=1, other ports' errors 0.
- 4 body flits on port 1 VC1 then a 5th flit with no returns -> credit 0, vc_credit_ok[1][1]=0, 5th flit sets err_credit[1], credit stays 0.
- On port 0 VC3 with credit 2: send and credit return in the same cycle -> credit stays 2, no error. Extra credit return at credit=4 -> saturates at 4, err_credit[0]=1.
- VC_TIMEOUT_EN with TIMEOUT_CYC=8: tail sent, no credits returned -> VC forced IDLE after 8 DRAIN cycles, credit=4, err_credit set. Macro undefined: VC stays DRAIN after 100 cycles.
